// File: rtl/config_pkg.sv
// Shared constants and parser state encoding for the ALU command packet receiver.
package config_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hAC;
    localparam logic [7:0] OP_DIV  = 8'hD1;

    localparam int HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RSVD     = 3'd1,
        ST_LEN_LO   = 3'd2,
        ST_LEN_HI   = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_ISSUE    = 3'd6,
        ST_WAIT_ALU = 3'd7
    } rx_state_e;

    function automatic logic op_known(input logic [7:0] op);
        logic known;
        case (op)
            OP_ECHO, OP_ADD, OP_MUL, OP_DIV: known = 1'b1;
            default:                         known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_rx_timeout.sv
// Inter-byte watchdog: reloads on clr, counts down while enabled, pulses expire at zero.
module alu_rx_timeout #(
    parameter int timeout_cycles_p = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (timeout_cycles_p > 2) ? $clog2(timeout_cycles_p) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(timeout_cycles_p - 1);

    logic [CW-1:0] cnt_r;

    // Down-counter; holds at zero until the parser leaves the counting states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= LOAD_VAL;
        end else if (clr) begin
            cnt_r <= LOAD_VAL;
        end else if (en && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en & ~clr & (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/alu_packet_rx.sv
// Parses UART command packets (opcode, reserved, 16-bit length, payload) into
// ALU operands and issues a one-cycle start pulse once the ALU is free.
module alu_packet_rx
    import config_pkg::*;
#(
    parameter int max_payload_p    = 8,
    parameter int timeout_cycles_p = 1200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic        busy_i,
    output logic [7:0]  opcode_o,
    output logic [1:0]  top_byte_o,
    output logic [32:0] data1_o,
    output logic        data1_valid_o,
    output logic [32:0] data2_o,
    output logic        data2_valid_o,
    output logic        start_alu_o,
    output logic        err_o
);

    rx_state_e   state_r, state_nx_s, issue_nx_s;
    logic        ready_r, start_r, err_r, first_r;
    logic [7:0]  opcode_r, len_lo_r;
    logic [15:0] plen_r, idx_r;
    logic [31:0] data1_r, data2_r;
    logic        v1_r, v2_r;
    logic [1:0]  top_r;
    logic        xfer_s, counting_s, expire_s, last_s;
    logic [15:0] len_s, plen_s;

    assign xfer_s     = rx_valid_i & ready_r;
    assign len_s      = {rx_data_i, len_lo_r};
    assign plen_s     = len_s - 16'(HDR_BYTES);
    assign last_s     = (idx_r == (plen_r - 16'd1));
    assign counting_s = state_r inside {ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_DRAIN};
    assign issue_nx_s = busy_i ? ST_ISSUE : ST_WAIT_ALU;

    alu_rx_timeout #(
        .timeout_cycles_p(timeout_cycles_p)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (xfer_s | ~counting_s),
        .en    (counting_s),
        .expire(expire_s)
    );

    // Next-state decode; a free ALU lets the parser skip ISSUE so start follows the last byte directly
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) state_nx_s = ST_RSVD;
                else        state_nx_s = ST_IDLE;
            end
            ST_RSVD: begin
                if (xfer_s)        state_nx_s = ST_LEN_LO;
                else if (expire_s) state_nx_s = ST_IDLE;
                else               state_nx_s = ST_RSVD;
            end
            ST_LEN_LO: begin
                if (xfer_s)        state_nx_s = ST_LEN_HI;
                else if (expire_s) state_nx_s = ST_IDLE;
                else               state_nx_s = ST_LEN_LO;
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    if (len_s < 16'(HDR_BYTES))                 state_nx_s = ST_IDLE;
                    else if (plen_s == 16'd0)                   state_nx_s = issue_nx_s;
                    else if (!op_known(opcode_r))               state_nx_s = ST_DRAIN;
                    else if (plen_s > 16'(max_payload_p))       state_nx_s = ST_DRAIN;
                    else                                        state_nx_s = ST_PAYLOAD;
                end else if (expire_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_LEN_HI;
                end
            end
            ST_PAYLOAD: begin
                if (xfer_s && last_s) state_nx_s = issue_nx_s;
                else if (xfer_s)      state_nx_s = ST_PAYLOAD;
                else if (expire_s)    state_nx_s = ST_IDLE;
                else                  state_nx_s = ST_PAYLOAD;
            end
            ST_DRAIN: begin
                if (xfer_s && last_s) state_nx_s = ST_IDLE;
                else if (expire_s)    state_nx_s = ST_IDLE;
                else                  state_nx_s = ST_DRAIN;
            end
            ST_ISSUE: begin
                if (!busy_i) state_nx_s = ST_WAIT_ALU;
                else         state_nx_s = ST_ISSUE;
            end
            ST_WAIT_ALU: begin
                if (!first_r && !busy_i) state_nx_s = ST_IDLE;
                else                     state_nx_s = ST_WAIT_ALU;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, pulses and operand registers; any drop back to IDLE from a receiving state is an error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            ready_r  <= 1'b0;
            start_r  <= 1'b0;
            err_r    <= 1'b0;
            first_r  <= 1'b0;
            opcode_r <= 8'h00;
            len_lo_r <= 8'h00;
            plen_r   <= 16'h0000;
            idx_r    <= 16'h0000;
            data1_r  <= 32'h0000_0000;
            data2_r  <= 32'h0000_0000;
            v1_r     <= 1'b0;
            v2_r     <= 1'b0;
            top_r    <= 2'd0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= !(state_nx_s inside {ST_ISSUE, ST_WAIT_ALU});
            start_r <= (state_nx_s == ST_WAIT_ALU) && (state_r != ST_WAIT_ALU);
            first_r <= (state_nx_s == ST_WAIT_ALU) && (state_r != ST_WAIT_ALU);
            err_r   <= counting_s && (state_nx_s == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        opcode_r <= rx_data_i;
                        data1_r  <= 32'h0000_0000;
                        data2_r  <= 32'h0000_0000;
                        v1_r     <= 1'b0;
                        v2_r     <= 1'b0;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer_s) len_lo_r <= rx_data_i;
                end
                ST_LEN_HI: begin
                    if (xfer_s) begin
                        plen_r <= plen_s;
                        idx_r  <= 16'h0000;
                        top_r  <= (plen_s >= 16'd4) ? 2'd0 : plen_s[1:0];
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer_s) begin
                        idx_r <= idx_r + 16'd1;
                        if (idx_r < 16'd4) begin
                            data1_r[{idx_r[1:0], 3'b000} +: 8] <= rx_data_i;
                            v1_r <= 1'b1;
                        end else begin
                            data2_r[{idx_r[1:0], 3'b000} +: 8] <= rx_data_i;
                            v2_r <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer_s) idx_r <= idx_r + 16'd1;
                end
                ST_WAIT_ALU: begin
                    if (state_nx_s == ST_IDLE) begin
                        data1_r <= 32'h0000_0000;
                        data2_r <= 32'h0000_0000;
                        v1_r    <= 1'b0;
                        v2_r    <= 1'b0;
                    end
                end
                default: idx_r <= idx_r;
            endcase
        end
    end

    assign rx_ready_o    = ready_r;
    assign opcode_o      = opcode_r;
    assign top_byte_o    = top_r;
    assign data1_o       = {1'b0, data1_r};
    assign data2_o       = {1'b0, data2_r};
    assign data1_valid_o = v1_r;
    assign data2_valid_o = v2_r;
    assign start_alu_o   = start_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_alu_packet_rx.sv
// Self-checking bench for alu_packet_rx: directed scenarios plus random packets
// compared against a packet-level reference model.
module tb_alu_packet_rx;

    localparam int TO   = 40;
    localparam int MAXP = 8;

    typedef struct {
        bit         is_start;
        logic [7:0] op;
        logic [32:0] d1, d2;
        logic       v1, v2;
        logic [1:0] top;
    } exp_t;

    typedef struct {
        int          n_start, n_err, lat;
        logic [7:0]  op;
        logic [32:0] d1, d2;
        logic        v1, v2, rdy;
        logic [1:0]  top;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        busy = 1'b0;
    logic        rx_ready_o, data1_valid_o, data2_valid_o, start_alu_o, err_o;
    logic [7:0]  opcode_o;
    logic [1:0]  top_byte_o;
    logic [32:0] data1_o, data2_o;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, start_cnt = 0, err_cnt = 0, start_cyc = 0, last_acc = 0;
    logic [7:0]  cap_op;
    logic [32:0] cap_d1, cap_d2;
    logic        cap_v1, cap_v2, cap_rdy;
    logic [1:0]  cap_top;

    alu_packet_rx #(.max_payload_p(MAXP), .timeout_cycles_p(TO)) dut (
        .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready_o), .busy_i(busy), .opcode_o(opcode_o),
        .top_byte_o(top_byte_o), .data1_o(data1_o), .data1_valid_o(data1_valid_o),
        .data2_o(data2_o), .data2_valid_o(data2_valid_o),
        .start_alu_o(start_alu_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts start/err pulses and captures the operands seen with each start
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #2;
        if (start_alu_o === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
            cap_op = opcode_o; cap_d1 = data1_o; cap_d2 = data2_o;
            cap_v1 = data1_valid_o; cap_v2 = data2_valid_o;
            cap_top = top_byte_o; cap_rdy = rx_ready_o;
        end
        if (err_o === 1'b1) err_cnt = err_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t model(input logic [7:0] pkt[$]);
        exp_t e;
        int len, plen;
        bit known;
        e.is_start = 1'b0; e.op = pkt[0]; e.d1 = 33'd0; e.d2 = 33'd0;
        e.v1 = 1'b0; e.v2 = 1'b0; e.top = 2'd0;
        len   = int'(pkt[2]) + 256 * int'(pkt[3]);
        plen  = len - 4;
        known = (pkt[0] == 8'hEC) || (pkt[0] == 8'hAD) || (pkt[0] == 8'hAC) || (pkt[0] == 8'hD1);
        if (len < 4) return e;
        if (plen == 0) begin e.is_start = 1'b1; return e; end
        if (!known || plen > MAXP) return e;
        e.is_start = 1'b1;
        for (int k = 0; k < plen; k++) begin
            if (k < 4) e.d1 = e.d1 + (33'(pkt[4+k]) << (8*k));
            else       e.d2 = e.d2 + (33'(pkt[4+k]) << (8*(k-4)));
        end
        e.v1  = 1'b1;
        e.v2  = (plen > 4);
        e.top = (plen >= 4) ? 2'd0 : 2'(plen);
        return e;
    endfunction

    task automatic from_vec(input logic [95:0] v, input int n, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic make_pkt(input logic [7:0] op, input int len, output logic [7:0] q[$]);
        q.delete();
        q.push_back(op);
        q.push_back(8'($urandom));
        q.push_back(len[7:0]);
        q.push_back(len[15:8]);
        for (int k = 0; k < len - 4; k++) q.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        rx_data = b; rx_valid = 1'b1; guard = 0;
        while (rx_ready_o !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte: byte %h never accepted, rx_ready_o=%b required 1", b, rx_ready_o);
        end
        @(negedge clk);
        last_acc = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic drive_pkt(input logic [7:0] pkt[$], input int maxgap, input bit rand_busy, output obs_t o);
        int s0, e0, guard;
        s0 = start_cnt; e0 = err_cnt;
        busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
        foreach (pkt[i]) send_byte(pkt[i], $urandom_range(0, maxgap));
        guard = 0;
        while (start_cnt == s0 && err_cnt == e0 && guard < 400) begin
            if (rand_busy) busy = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        busy = 1'b0;
        repeat (4) @(negedge clk);
        o.n_start = start_cnt - s0; o.n_err = err_cnt - e0; o.lat = start_cyc - last_acc;
        o.op = cap_op; o.d1 = cap_d1; o.d2 = cap_d2; o.v1 = cap_v1; o.v2 = cap_v2;
        o.top = cap_top; o.rdy = cap_rdy;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({opcode_o, top_byte_o, data1_o, data2_o, data1_valid_o, data2_valid_o, start_alu_o, err_o, rx_ready_o} !== 79'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: op=%h top=%0d d1=%h d2=%h v=%b%b start=%b err=%b rdy=%b required all 0",
                     opcode_o, top_byte_o, data1_o, data2_o, data1_valid_o, data2_valid_o, start_alu_o, err_o, rx_ready_o);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rx_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready_held: got %b required 0", rx_ready_o); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rx_ready_o !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b required 1", rx_ready_o); end
    endtask

    task automatic test_add();
        logic [7:0] q[$];
        obs_t o;
        from_vec(96'hAD000C00_01000000_02000000, 12, q);
        drive_pkt(q, 1, 1'b0, o);
        n_cmp++;
        if (o.n_start != 1 || o.n_err != 0) begin n_bad++; $display("FAIL add_pulses: start=%0d err=%0d required 1/0", o.n_start, o.n_err); end
        n_cmp++;
        if (o.op !== 8'hAD || o.d1 !== 33'd1 || o.d2 !== 33'd2) begin
            n_bad++; $display("FAIL add_operands: op=%h d1=%h d2=%h required AD/1/2", o.op, o.d1, o.d2);
        end
        n_cmp++;
        if (o.v1 !== 1'b1 || o.v2 !== 1'b1 || o.top !== 2'd0 || o.rdy !== 1'b0) begin
            n_bad++; $display("FAIL add_flags: v1=%b v2=%b top=%0d rdy=%b required 1/1/0/0", o.v1, o.v2, o.top, o.rdy);
        end
        n_cmp++;
        if (o.lat != 0) begin n_bad++; $display("FAIL add_start_latency: got %0d cycles after last byte edge required 0", o.lat); end
    endtask

    task automatic test_echo();
        logic [7:0] pay[3];
        int s0;
        pay[0] = 8'h41; pay[1] = 8'h42; pay[2] = 8'h43;
        s0 = start_cnt;
        send_byte(8'hEC, 0); send_byte(8'h00, 0); send_byte(8'h07, 0); send_byte(8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            send_byte(pay[k], 0);
            n_cmp++;
            if (data1_o[8*k +: 8] !== pay[k] || data1_valid_o !== 1'b1) begin
                n_bad++; $display("FAIL echo_byte_latency: byte%0d got %h v1=%b required %h v1=1", k, data1_o[8*k +: 8], data1_valid_o, pay[k]);
            end
        end
        n_cmp++;
        if (start_alu_o !== 1'b1) begin n_bad++; $display("FAIL echo_earliest_start: start=%b required 1", start_alu_o); end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (start_cnt - s0 != 1 || cap_d1 !== 33'h434241 || cap_v1 !== 1'b1 || cap_v2 !== 1'b0 || cap_top !== 2'd3) begin
            n_bad++; $display("FAIL echo_result: starts=%0d d1=%h v1=%b v2=%b top=%0d required 1/434241/1/0/3",
                              start_cnt - s0, cap_d1, cap_v1, cap_v2, cap_top);
        end
    endtask

    task automatic test_busy();
        logic [7:0] q[$];
        int s0, guard, bad;
        from_vec(96'hAC000800_03000000, 8, q);
        s0 = start_cnt;
        foreach (q[i]) send_byte(q[i], 0);
        guard = 0;
        while (start_cnt == s0 && guard < 50) begin @(negedge clk); guard++; end
        busy = 1'b1; rx_data = 8'hEC; rx_valid = 1'b1; bad = 0;
        if (rx_ready_o !== 1'b0) bad++;
        repeat (5) begin
            @(negedge clk);
            if (rx_ready_o !== 1'b0 || opcode_o !== 8'hAC || data1_o !== 33'd3) bad++;
        end
        n_cmp++;
        if (start_cnt - s0 != 1 || bad != 0) begin
            n_bad++; $display("FAIL busy_hold: starts=%0d violations=%0d required 1/0", start_cnt - s0, bad);
        end
        busy = 1'b0; guard = 0;
        while (rx_ready_o !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        rx_valid = 1'b0;
        n_cmp++;
        if (opcode_o !== 8'hEC) begin n_bad++; $display("FAIL busy_next_opcode: got %h required EC", opcode_o); end
        s0 = start_cnt;
        send_byte(8'h00, 0); send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h99, 0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (start_cnt - s0 != 1 || cap_d1 !== 33'h99 || cap_op !== 8'hEC) begin
            n_bad++; $display("FAIL busy_next_packet: starts=%0d op=%h d1=%h required 1/EC/99", start_cnt - s0, cap_op, cap_d1);
        end
    endtask

    task automatic test_drain();
        logic [7:0] q[$];
        obs_t o;
        exp_t e;
        from_vec(96'h55000600_AABB, 6, q);
        drive_pkt(q, 0, 1'b0, o);
        n_cmp++;
        if (o.n_err != 1 || o.n_start != 0) begin n_bad++; $display("FAIL drain_pulses: err=%0d start=%0d required 1/0", o.n_err, o.n_start); end
        make_pkt(8'hAD, 12, q);
        e = model(q);
        drive_pkt(q, 1, 1'b0, o);
        n_cmp++;
        if (o.n_start != 1 || o.n_err != 0 || o.d1 !== e.d1 || o.d2 !== e.d2 || o.op !== 8'hAD) begin
            n_bad++; $display("FAIL drain_recovery: start=%0d err=%0d d1=%h d2=%h required 1/0 %h %h", o.n_start, o.n_err, o.d1, o.d2, e.d1, e.d2);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] q[$];
        obs_t o;
        int s0, e0, n;
        s0 = start_cnt;
        from_vec(96'hAD000C00_112233, 7, q);
        foreach (q[i]) send_byte(q[i], 0);
        e0 = err_cnt; n = 0;
        while (err_cnt == e0 && n < 3 * TO) begin @(negedge clk); n++; end
        n_cmp++;
        if (err_cnt - e0 != 1 || start_cnt != s0 || n < TO - 1 || n > TO + 2) begin
            n_bad++; $display("FAIL timeout_abort: err=%0d starts=%0d idle=%0d required 1/0/%0d..%0d", err_cnt - e0, start_cnt - s0, n, TO - 1, TO + 2);
        end
        from_vec(96'hEC000500_5A, 5, q);
        drive_pkt(q, 0, 1'b0, o);
        n_cmp++;
        if (o.n_start != 1 || o.n_err != 0 || o.op !== 8'hEC || o.d1 !== 33'h5A) begin
            n_bad++; $display("FAIL timeout_resync: start=%0d err=%0d op=%h d1=%h required 1/0/EC/5A", o.n_start, o.n_err, o.op, o.d1);
        end
        // Slow but legal sender: gaps just under the timeout must not abort
        from_vec(96'hD1000600_7788, 6, q);
        s0 = start_cnt; e0 = err_cnt;
        foreach (q[i]) send_byte(q[i], TO - 4);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (start_cnt - s0 != 1 || err_cnt != e0 || cap_d1 !== 33'h8877) begin
            n_bad++; $display("FAIL timeout_slow_sender: starts=%0d errs=%0d d1=%h required 1/0/8877", start_cnt - s0, err_cnt - e0, cap_d1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        obs_t o;
        exp_t e;
        int s0, e0;
        from_vec(96'hAD000C00_CAFE, 6, q);
        foreach (q[i]) send_byte(q[i], 0);
        s0 = start_cnt; e0 = err_cnt;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({opcode_o, top_byte_o, data1_o, data2_o, data1_valid_o, data2_valid_o, start_alu_o, err_o, rx_ready_o} !== 79'd0) begin
            n_bad++; $display("FAIL midreset_outputs: op=%h d1=%h v1=%b rdy=%b required all 0", opcode_o, data1_o, data1_valid_o, rx_ready_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (start_cnt != s0 || err_cnt != e0) begin
            n_bad++; $display("FAIL midreset_pulses: starts=%0d errs=%0d required 0/0", start_cnt - s0, err_cnt - e0);
        end
        make_pkt(8'hAC, 10, q);
        e = model(q);
        drive_pkt(q, 1, 1'b0, o);
        n_cmp++;
        if (o.n_start != 1 || o.d1 !== e.d1 || o.d2 !== e.d2 || o.v2 !== 1'b1 || o.top !== 2'd0) begin
            n_bad++; $display("FAIL midreset_recovery: start=%0d d1=%h d2=%h v2=%b top=%0d required 1 %h %h 1 0", o.n_start, o.d1, o.d2, o.v2, o.top, e.d1, e.d2);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] op;
        obs_t o;
        exp_t e;
        int len;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       op = 8'hEC;
                1:       op = 8'hAD;
                2:       op = 8'hAC;
                3:       op = 8'hD1;
                default: op = 8'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0:       len = $urandom_range(0, 3);
                1:       len = 4;
                2:       len = $urandom_range(13, 15);
                default: len = $urandom_range(5, 12);
            endcase
            make_pkt(op, len, q);
            e = model(q);
            drive_pkt(q, 2, 1'b1, o);
            if (e.is_start)
                ok = (o.n_start == 1) && (o.n_err == 0) && (o.op === e.op) && (o.d1 === e.d1) && (o.d2 === e.d2)
                     && (o.v1 === e.v1) && (o.v2 === e.v2) && (o.top === e.top);
            else
                ok = (o.n_start == 0) && (o.n_err == 1);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL random_pkt%0d op=%h len=%0d: start=%0d err=%0d d1=%h d2=%h v=%b%b top=%0d required start=%0d d1=%h d2=%h v=%b%b top=%0d",
                         i, op, len, o.n_start, o.n_err, o.d1, o.d2, o.v1, o.v2, o.top, e.is_start, e.d1, e.d2, e.v1, e.v2, e.top);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_echo();
        test_busy();
        test_drain();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
